// File: rtl/pipe_mux_pkg.sv
// Shared constants and select-width helper for pipe_mux and its channel mux.
package pipe_mux_pkg;

    localparam int unsigned DEFAULT_WIDTH  = 32;
    localparam int unsigned DEFAULT_NUM_IN = 8;

    function automatic int unsigned sel_width(input int unsigned num_in);
        return (num_in > 1) ? $clog2(num_in) : 1;
    endfunction

endpackage

// File: rtl/pipe_mux_mux_n_comb.sv
// Combinational N-to-1 channel selector; any sel at or above NUM_IN yields all-zero data.
module mux_n_comb
    import pipe_mux_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned NUM_IN = DEFAULT_NUM_IN,
    parameter int unsigned SEL_W  = sel_width(NUM_IN)
) (
    input  logic [NUM_IN*WIDTH-1:0] x,
    input  logic [SEL_W-1:0]        sel,
    output logic [WIDTH-1:0]        y
);

    always_comb begin
        y = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (32'(sel) == i) y = x[i*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/pipe_mux.sv
// Registered channel mux behind a 2-entry skid buffer (output reg + skid reg).
// Define PIPE_MUX_SEL_CHECK_EN to build the out-of-range sel flag that travels with each item.
module pipe_mux
    import pipe_mux_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned NUM_IN = DEFAULT_NUM_IN,
    parameter int unsigned SEL_W  = sel_width(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] x,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        y,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    logic [WIDTH-1:0] mux_data;
    logic             out_valid_q;
    logic             skid_valid_q;
    logic             in_ready_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] skid_data_q;
    logic             accept;
    logic             deliver;
    logic             load_out;

    mux_n_comb #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN),
        .SEL_W  (SEL_W)
    ) u_mux (
        .x   (x),
        .sel (sel),
        .y   (mux_data)
    );

    assign accept   = in_valid && in_ready_q;
    assign deliver  = out_valid_q && out_ready;
    assign load_out = !out_valid_q || deliver;

    // in_ready_q mirrors !skid_valid_q as its own flop so it never depends on out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
            y_q          <= '0;
            skid_data_q  <= '0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else if (load_out) begin
            if (skid_valid_q) begin
                // A full skid means in_ready was low, so no accept can coincide here.
                y_q          <= skid_data_q;
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
                in_ready_q   <= 1'b1;
            end else begin
                out_valid_q <= accept;
                if (accept) y_q <= mux_data;
            end
        end else if (accept) begin
            skid_data_q  <= mux_data;
            skid_valid_q <= 1'b1;
            in_ready_q   <= 1'b0;
        end
    end

`ifdef PIPE_MUX_SEL_CHECK_EN
    logic sel_oor;
    logic err_q;
    logic skid_err_q;

    assign sel_oor = 32'(sel) >= NUM_IN;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q      <= 1'b0;
            skid_err_q <= 1'b0;
        end else if (!flush) begin
            if (load_out) begin
                if (skid_valid_q) err_q <= skid_err_q;
                else if (accept) err_q <= sel_oor;
            end else if (accept) begin
                skid_err_q <= sel_oor;
            end
        end
    end

    assign sel_err = err_q;
`else
    assign sel_err = 1'b0;
`endif

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign y         = y_q;

endmodule

// File: tb/tb_pipe_mux.sv
// Randomised scoreboard bench for pipe_mux: an 8-input and a 5-input instance share all stimulus.
module tb_pipe_mux;

    localparam int W = 32;

    typedef struct packed {
        logic         err;
        logic [W-1:0] data;
    } item_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [8*W-1:0] x = '0;
    logic [2:0]     sel = '0;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b0;
    logic           flush = 1'b0;

    logic           in_ready_a, out_valid_a, err_a;
    logic [W-1:0]   y_a;
    logic           in_ready_b, out_valid_b, err_b;
    logic [W-1:0]   y_b;

    item_t qa[$];
    item_t qb[$];
    item_t pend_a, pend_b;
    logic  acc_pend = 1'b0;
    logic  fl_pend = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_mux #(
        .WIDTH  (W),
        .NUM_IN (8)
    ) dut_a (
        .clk       (clk),
        .rst       (rst),
        .x         (x),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready_a),
        .flush     (flush),
        .y         (y_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready),
        .sel_err   (err_a)
    );

    pipe_mux #(
        .WIDTH  (W),
        .NUM_IN (5)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .x         (x[5*W-1:0]),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready_b),
        .flush     (flush),
        .y         (y_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready),
        .sel_err   (err_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic item_t model_a(input logic [8*W-1:0] xv, input logic [2:0] s);
        item_t it;
        it.data = xv[s*W +: W];
        it.err  = 1'b0;
        return it;
    endfunction

    function automatic item_t model_b(input logic [8*W-1:0] xv, input logic [2:0] s);
        item_t it;
        it.data = (s < 3'd5) ? xv[s*W +: W] : '0;
`ifdef PIPE_MUX_SEL_CHECK_EN
        it.err = (s >= 3'd5);
`else
        it.err = 1'b0;
`endif
        return it;
    endfunction

    function automatic logic [8*W-1:0] rand_x();
        logic [8*W-1:0] v;
        for (int i = 0; i < 8; i++) v[i*W +: W] = $urandom;
        return v;
    endfunction

    function automatic logic [8*W-1:0] chan(input int c, input logic [W-1:0] v);
        logic [8*W-1:0] r;
        r = rand_x();
        r[c*W +: W] = v;
        return r;
    endfunction

    // Apply one cycle of stimulus and record what the reference buffer will do at the next edge.
    task automatic drive(input logic v, input logic [8*W-1:0] xv, input logic [2:0] s,
                         input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        in_valid  = v;
        x         = xv;
        sel       = s;
        out_ready = ordy;
        flush     = fl;
        acc_pend  = v && (qa.size() < 2);
        fl_pend   = fl;
        pend_a    = model_a(xv, s);
        pend_b    = model_b(xv, s);
    endtask

    always @(posedge clk) begin
        if (!rst) begin
            if (fl_pend) begin
                qa.delete();
                qb.delete();
            end else if (acc_pend) begin
                qa.push_back(pend_a);
                qb.push_back(pend_b);
            end
        end
    end

    // Monitor: compare handshake state and head-of-queue data, pop on delivery.
    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready_a", 64'(in_ready_a), 64'(qa.size() < 2));
            check("out_valid_a", 64'(out_valid_a), 64'(qa.size() > 0));
            check("in_ready_b", 64'(in_ready_b), 64'(qb.size() < 2));
            check("out_valid_b", 64'(out_valid_b), 64'(qb.size() > 0));
            if (qa.size() > 0) begin
                check("y_a", 64'(y_a), 64'(qa[0].data));
                check("sel_err_a", 64'(err_a), 64'(qa[0].err));
                if (out_ready) void'(qa.pop_front());
            end
            if (qb.size() > 0) begin
                check("y_b", 64'(y_b), 64'(qb[0].data));
                check("sel_err_b", 64'(err_b), 64'(qb[0].err));
                if (out_ready) void'(qb.pop_front());
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("reset_y_a", 64'(y_a), 64'h0);
        check("reset_err_a", 64'(err_a), 64'h0);
        check("reset_valid_a", 64'(out_valid_a), 64'h0);
        check("reset_ready_a", 64'(in_ready_a), 64'h1);
        check("reset_y_b", 64'(y_b), 64'h0);
        check("reset_err_b", 64'(err_b), 64'h0);

        // Single item on channel 3
        drive(1'b1, chan(3, 32'h0000_0033), 3'd3, 1'b1, 1'b0);
        repeat (3) drive(1'b0, rand_x(), 3'd0, 1'b1, 1'b0);

        // Back-pressure: two items stall, then drain back to back
        drive(1'b1, chan(1, 32'hA1), 3'd1, 1'b0, 1'b0);
        drive(1'b1, chan(2, 32'hB2), 3'd2, 1'b0, 1'b0);
        repeat (3) drive(1'b0, rand_x(), 3'd0, 1'b0, 1'b0);
        repeat (3) drive(1'b0, rand_x(), 3'd0, 1'b1, 1'b0);

        // Streaming at full rate
        for (int i = 0; i < 16; i++) drive(1'b1, rand_x(), 3'(i % 8), 1'b1, 1'b0);
        repeat (2) drive(1'b0, rand_x(), 3'd0, 1'b1, 1'b0);

        // Flush while full, with a concurrent offer that must be dropped
        drive(1'b1, rand_x(), 3'd0, 1'b0, 1'b0);
        drive(1'b1, rand_x(), 3'd1, 1'b0, 1'b0);
        drive(1'b1, rand_x(), 3'd4, 1'b0, 1'b1);
        drive(1'b0, rand_x(), 3'd0, 1'b0, 1'b0);
        drive(1'b0, rand_x(), 3'd0, 1'b1, 1'b0);

        // Out-of-range selects for the 5-input instance
        drive(1'b1, rand_x(), 3'd6, 1'b1, 1'b0);
        drive(1'b1, rand_x(), 3'd5, 1'b1, 1'b0);
        drive(1'b1, rand_x(), 3'd7, 1'b0, 1'b0);
        drive(1'b1, rand_x(), 3'd4, 1'b0, 1'b0);
        repeat (3) drive(1'b0, rand_x(), 3'd0, 1'b1, 1'b0);

        for (int i = 0; i < 600; i++)
            drive(($urandom_range(0, 9) < 7), rand_x(), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 9) < 6), ($urandom_range(0, 39) == 0));

        // Asynchronous reset while full
        repeat (3) drive(1'b0, rand_x(), 3'd0, 1'b1, 1'b0);
        drive(1'b1, rand_x(), 3'd2, 1'b0, 1'b0);
        drive(1'b1, rand_x(), 3'd3, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        acc_pend = 1'b0;
        fl_pend  = 1'b0;
        qa.delete();
        qb.delete();
        #1;
        check("async_valid_a", 64'(out_valid_a), 64'h0);
        check("async_ready_a", 64'(in_ready_a), 64'h1);
        check("async_y_a", 64'(y_a), 64'h0);
        check("async_valid_b", 64'(out_valid_b), 64'h0);
        check("async_ready_b", 64'(in_ready_b), 64'h1);
        #1 rst = 1'b0;

        drive(1'b1, chan(0, 32'h1234_5678), 3'd0, 1'b1, 1'b0);
        for (int i = 0; i < 100; i++)
            drive(($urandom_range(0, 9) < 8), rand_x(), 3'($urandom_range(0, 7)),
                  ($urandom_range(0, 9) < 5), 1'b0);
        repeat (4) drive(1'b0, rand_x(), 3'd0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
